axis_round_robin_arbiter: RTL and testbench
===========================================

# axis_round_robin_arbiter

Packet-level round-robin arbiter that drives the one-hot channel select of the AXI-Stream round-robin mux. It watches the per-channel `tvalid` and `tlast` signals and the downstream `tready`. It grants one channel at a time, holds the grant until that channel's `tlast` beat is accepted, then rotates priority so that every requester is served fairly. It sits beside the mux in the same clock domain. Its `sel_o` connects directly to the mux select input.

## Interface
- `CHANNEL_NUM`, default 8: number of input streams. Legal range 2..32.
- `IDX_WIDTH` (localparam), `$clog2(CHANNEL_NUM)`: width of the binary grant index.
- `clk_i`  input  1: the single clock. All logic is rising-edge.
- `rst_i`  input  1: reset, asynchronous and active-high.
- `s_axis_tvalid`  input  CHANNEL_NUM: per-channel request. Bit i is channel i's `tvalid`.
- `s_axis_tlast`  input  CHANNEL_NUM: per-channel `tlast`.
- `m_axis_tready`  input  1: downstream ready, taken after the mux.
- `sel_o`  output  CHANNEL_NUM: registered one-hot grant. All-zero when no grant is held.
- `grant_idx_o`  output  IDX_WIDTH: binary index of the granted channel. Valid only while `grant_active_o` is high.
- `grant_active_o`  output  1: high while a grant is held. The mux output `tvalid` must be gated with this signal.

## Operation
- State machine with two states, IDLE and LOCKED. Reset state is IDLE.
- A priority pointer `ptr` (IDX_WIDTH bits) gives the highest-priority channel. Priority descends `ptr`, `ptr+1`, … modulo CHANNEL_NUM.
- **IDLE:**
  - If any `s_axis_tvalid` bit is set, pick the first set bit in rotated order from `ptr`.
  - Register it into `sel_o` and `grant_idx_o`, set `grant_active_o`, and move to LOCKED.
  - If no bit is set, stay in IDLE with all outputs zero.
- **LOCKED, grant g:**
  - A beat is accepted when `s_axis_tvalid[g] & m_axis_tready` is high.
  - An accepted beat with `s_axis_tlast[g]=1` releases the grant. On release, `ptr` becomes g+1, wrapping from CHANNEL_NUM-1 to 0.
  - In the release cycle, re-arbitrate over the request vector with bit g masked, starting at g+1.
    - If another channel is requesting, go directly to LOCKED with the new grant. There is no bubble.
    - Otherwise go to IDLE and drive `sel_o` to zero.
  - While LOCKED, changes on other channels' requests are ignored.
  - A deasserted `s_axis_tvalid[g]` in mid-packet does not release the grant.
- A channel that is the only requester re-enters arbitration after one IDLE cycle.
- Input `tvalid` must not be dropped before its handshake, per AXIS rules. The arbiter relies on this and does not re-check `tvalid` after granting.

## Timing
- **Reset values:** `sel_o=0`, `grant_idx_o=0`, `grant_active_o=0`, `ptr=0`, state IDLE.
- An asynchronous assert clears all of these immediately. This also applies mid-packet: the packet is abandoned with no completion.
- Deassertion is synchronised externally. The first arbitration happens on the first clock edge after release.
- **Grant latency:** a request seen in IDLE at edge N produces `sel_o` at edge N+1.
- **Release latency:** a `tlast` handshake at edge N makes the new grant, or zero, visible at edge N+1. The last beat itself is transferred under the old `sel_o` during cycle N.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `axis_rr_pkg` contains:
  - the state enum `rr_state_t` with values IDLE and LOCKED;
  - the function `onehot_from_idx`;
  - the default `CHANNEL_NUM`.
- Sub-module `rr_priority_encoder`: a combinational block.
  - Inputs: request vector, mask, and `ptr`.
  - Outputs: `found` and the index of the first set bit in rotated order.
  - It is instantiated once and shared by the IDLE path and the release path.

## Test plan
- **Reset and single requester:** pulse `rst_i`, then raise `s_axis_tvalid=8'h04` with `m_axis_tready=1`. Expect `sel_o=8'h04` and `grant_idx_o=2` one edge later. After a 4-beat packet, `sel_o=0` on the edge after the `tlast` beat, and `ptr=3`.
- **Fairness:** with `s_axis_tvalid=8'hFF` held continuously and 2-beat packets, grants follow 0,1,…,7,0 with no idle cycle between packets.
- **Backpressure:** while ch5 is granted, hold `m_axis_tready=0` for 10 cycles with `tlast` high. Expect `sel_o=8'h20` to stay stable. Release happens only on the handshake edge.
- **Wrap and skip:** with `ptr=6` and requests `8'h03`, the grant is ch0. After its release, the grant is ch1.
- **Lone repeater:** ch3 sends back-to-back packets alone. Expect exactly one cycle of `sel_o=0` between packets, then regrant of ch3.
- **Reset mid-packet:** assert `rst_i` during beat 2 of a ch4 packet. All outputs read 0 immediately. After release, with request `8'h10`, the grant is ch4 again because `ptr` has returned to 0.

Source files
------------

// File: rtl/axis_rr_pkg.sv
// rtl/axis_rr_pkg.sv - shared types and helpers for the round-robin packet arbiter
package axis_rr_pkg;

    localparam int CHANNEL_NUM_DEFAULT = 8;
    localparam int MAX_CHANNELS        = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } rr_state_t;

    function automatic logic [MAX_CHANNELS-1:0] onehot_from_idx(input int unsigned idx);
        logic [MAX_CHANNELS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/axis_round_robin_arbiter_if.sv
// rtl/axis_round_robin_arbiter_if.sv - request/grant bundle between the streams and the arbiter
interface axis_round_robin_arbiter_if
    import axis_rr_pkg::*;
#(
    parameter int CHANNEL_NUM = CHANNEL_NUM_DEFAULT
);
    localparam int IDX_WIDTH = $clog2(CHANNEL_NUM);

    logic [CHANNEL_NUM-1:0] s_axis_tvalid;
    logic [CHANNEL_NUM-1:0] s_axis_tlast;
    logic                   m_axis_tready;
    logic [CHANNEL_NUM-1:0] sel_o;
    logic [IDX_WIDTH-1:0]   grant_idx_o;
    logic                   grant_active_o;

    modport master (
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  m_axis_tready,
        output sel_o,
        output grant_idx_o,
        output grant_active_o
    );

    modport slave (
        output s_axis_tvalid,
        output s_axis_tlast,
        output m_axis_tready,
        input  sel_o,
        input  grant_idx_o,
        input  grant_active_o
    );

endinterface

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - first set bit of (req & ~mask) searching upward from ptr, wrapping
module rr_priority_encoder #(
    parameter int CHANNEL_NUM = 8
) (
    input  logic [CHANNEL_NUM-1:0]         req_i,
    input  logic [CHANNEL_NUM-1:0]         mask_i,
    input  logic [$clog2(CHANNEL_NUM)-1:0] ptr_i,
    output logic                           found_o,
    output logic [$clog2(CHANNEL_NUM)-1:0] idx_o
);
    localparam int IDX_WIDTH = $clog2(CHANNEL_NUM);

    logic [CHANNEL_NUM-1:0] eligible;
    logic [IDX_WIDTH-1:0]   ch;

    assign eligible = req_i & ~mask_i;

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        ch      = '0;
        for (int off = CHANNEL_NUM - 1; off >= 0; off--) begin
            ch = IDX_WIDTH'((int'(ptr_i) + off) % CHANNEL_NUM);
            if (eligible[ch]) begin
                found_o = 1'b1;
                idx_o   = ch;
            end
        end
    end

endmodule

// File: rtl/axis_round_robin_arbiter.sv
// rtl/axis_round_robin_arbiter.sv - packet-level round-robin grant for the AXI-Stream mux select
module axis_round_robin_arbiter
    import axis_rr_pkg::*;
#(
    parameter int CHANNEL_NUM = CHANNEL_NUM_DEFAULT
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    axis_round_robin_arbiter_if.master        arb_if
);
    localparam int IDX_WIDTH = $clog2(CHANNEL_NUM);

    rr_state_t              state_q, state_d;
    logic [CHANNEL_NUM-1:0] sel_q, sel_d;
    logic [IDX_WIDTH-1:0]   grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic                   active_q, active_d;

    logic [CHANNEL_NUM-1:0] enc_mask;
    logic [IDX_WIDTH-1:0]   enc_ptr;
    logic [IDX_WIDTH-1:0]   enc_idx;
    logic                   enc_found;
    logic [IDX_WIDTH-1:0]   after_grant;
    logic                   release_w;

    assign after_grant = (grant_idx_q == IDX_WIDTH'(CHANNEL_NUM - 1)) ? '0
                                                                      : grant_idx_q + IDX_WIDTH'(1);

    assign release_w = (state_q == LOCKED)
                     & arb_if.s_axis_tvalid[grant_idx_q]
                     & arb_if.m_axis_tready
                     & arb_if.s_axis_tlast[grant_idx_q];

    // One encoder serves both paths: in IDLE it scans from ptr, on release it
    // scans from the channel after the finishing one with that channel masked.
    always_comb begin
        enc_mask = '0;
        enc_ptr  = ptr_q;
        if (state_q == LOCKED) begin
            enc_mask = CHANNEL_NUM'(onehot_from_idx(32'(grant_idx_q)));
            enc_ptr  = after_grant;
        end
    end

    rr_priority_encoder #(
        .CHANNEL_NUM (CHANNEL_NUM)
    ) u_enc (
        .req_i   (arb_if.s_axis_tvalid),
        .mask_i  (enc_mask),
        .ptr_i   (enc_ptr),
        .found_o (enc_found),
        .idx_o   (enc_idx)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        active_d    = active_q;
        case (state_q)
            IDLE: begin
                if (enc_found) begin
                    state_d     = LOCKED;
                    sel_d       = CHANNEL_NUM'(onehot_from_idx(32'(enc_idx)));
                    grant_idx_d = enc_idx;
                    active_d    = 1'b1;
                end
            end
            LOCKED: begin
                if (release_w) begin
                    ptr_d = after_grant;
                    if (enc_found) begin
                        sel_d       = CHANNEL_NUM'(onehot_from_idx(32'(enc_idx)));
                        grant_idx_d = enc_idx;
                    end else begin
                        state_d     = IDLE;
                        sel_d       = '0;
                        grant_idx_d = '0;
                        active_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                sel_d       = '0;
                grant_idx_d = '0;
                active_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            active_q    <= active_d;
        end
    end

    assign arb_if.sel_o          = sel_q;
    assign arb_if.grant_idx_o    = grant_idx_q;
    assign arb_if.grant_active_o = active_q;

endmodule

// File: tb/tb_axis_round_robin_arbiter.sv
// tb/tb_axis_round_robin_arbiter.sv - directed and randomized checks of the round-robin arbiter
module tb_axis_round_robin_arbiter;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] v   = '0;
    logic [N-1:0] l   = '0;
    logic         r   = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_owner = -1;
    int m_ptr   = 0;

    int pend_len [N];

    axis_round_robin_arbiter_if #(.CHANNEL_NUM(N)) bus ();

    assign bus.s_axis_tvalid = v;
    assign bus.s_axis_tlast  = l;
    assign bus.m_axis_tready = r;

    axis_round_robin_arbiter #(.CHANNEL_NUM(N)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .arb_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int excl, input int start);
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N] && ((start + k) % N) != excl)
                return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] es;
        es = (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
        chk({tag, ".sel"},    {24'h0, bus.sel_o}, es);
        chk({tag, ".idx"},    {29'h0, bus.grant_idx_o}, (m_owner < 0) ? 32'h0 : 32'(m_owner));
        chk({tag, ".active"}, {31'h0, bus.grant_active_o}, (m_owner < 0) ? 32'h0 : 32'h1);
    endtask

    // Advance the reference across one rising edge, then compare just after it.
    task automatic tick(input string tag);
        if (m_owner < 0) begin
            m_owner = pick(v, -1, m_ptr);
        end else if (v[m_owner] && r && l[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = pick(v, m_owner, m_ptr);
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        m_owner = -1;
        m_ptr   = 0;
        chk({tag, ".sel"},    {24'h0, bus.sel_o}, 32'h0);
        chk({tag, ".idx"},    {29'h0, bus.grant_idx_o}, 32'h0);
        chk({tag, ".active"}, {31'h0, bus.grant_active_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_ch;
        int o;
        #2;
        do_reset("reset");

        // Single requester, 4-beat packet on ch2
        v = 8'h04; l = 8'h00; r = 1'b1;
        tick("single.grant");
        chk("single.sel_const", {24'h0, bus.sel_o}, 32'h04);
        chk("single.idx_const", {29'h0, bus.grant_idx_o}, 32'd2);
        tick("single.b1");
        tick("single.b2");
        tick("single.b3");
        l = 8'h04;
        tick("single.last");
        chk("single.released", {24'h0, bus.sel_o}, 32'h0);
        // ptr now 3, so ch3 beats ch2
        v = 8'h0C; l = 8'h00;
        tick("ptr3.grant");
        chk("ptr3.sel_const", {24'h0, bus.sel_o}, 32'h08);
        l = 8'h08;
        tick("ptr3.handoff");
        chk("ptr3.no_bubble", {24'h0, bus.sel_o}, 32'h04);
        v = 8'h04; l = 8'h04;
        tick("ptr3.drain");

        // Fairness with everyone requesting and 2-beat packets
        do_reset("reset2");
        v = 8'hFF; l = 8'h00; r = 1'b1;
        tick("fair.first");
        chk("fair.first_const", {24'h0, bus.sel_o}, 32'h01);
        for (int k = 1; k <= 9; k++) begin
            l = 8'h00;
            tick("fair.beat1");
            l = 8'hFF;
            tick("fair.beat2");
            exp_ch = k % N;
            chk("fair.order", {24'h0, bus.sel_o}, 32'h1 << exp_ch);
        end

        // Backpressure on ch5 with tlast pending
        do_reset("reset3");
        v = 8'h20; l = 8'h00; r = 1'b1;
        tick("bp.grant");
        l = 8'h20; r = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick("bp.hold");
            chk("bp.hold_const", {24'h0, bus.sel_o}, 32'h20);
        end
        r = 1'b1;
        tick("bp.release");
        chk("bp.release_const", {24'h0, bus.sel_o}, 32'h0);

        // Wrap and skip from ptr=6
        v = 8'h03; l = 8'h00;
        tick("wrap.grant");
        chk("wrap.ch0", {24'h0, bus.sel_o}, 32'h01);
        l = 8'h01;
        tick("wrap.next");
        chk("wrap.ch1", {24'h0, bus.sel_o}, 32'h02);
        v = 8'h02; l = 8'h02;
        tick("wrap.drain");

        // Lone repeater on ch3
        v = 8'h08; l = 8'h00;
        tick("lone.grant");
        tick("lone.b1");
        l = 8'h08;
        tick("lone.last");
        chk("lone.gap", {24'h0, bus.sel_o}, 32'h0);
        l = 8'h00;
        tick("lone.regrant");
        chk("lone.regrant_const", {24'h0, bus.sel_o}, 32'h08);
        l = 8'h08;
        tick("lone.last2");
        v = 8'h00; l = 8'h00;
        tick("lone.idle");

        // Reset mid-packet on ch4
        v = 8'h10; l = 8'h00;
        tick("mid.grant");
        tick("mid.b1");
        @(negedge clk);
        do_reset("mid.reset");
        tick("mid.regrant");
        chk("mid.regrant_const", {24'h0, bus.sel_o}, 32'h10);
        l = 8'h10;
        tick("mid.last");
        // ptr=5 now: ch0 must lose to ch6
        v = 8'h41; l = 8'h00;
        tick("mid.ptr5");
        chk("mid.ptr5_const", {24'h0, bus.sel_o}, 32'h40);

        // Randomized traffic obeying the hold-until-handshake rule
        do_reset("reset4");
        v = '0; l = '0;
        for (int i = 0; i < N; i++) pend_len[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (pend_len[i] == 0 && ($urandom % 4) == 0)
                    pend_len[i] = 1 + int'($urandom % 4);
                v[i] = (pend_len[i] != 0);
                l[i] = (pend_len[i] == 1);
            end
            r = (($urandom % 4) != 0);
            o = m_owner;
            if (o >= 0 && v[o] && r)
                pend_len[o] = pend_len[o] - 1;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
